// File: rtl/xorshift32_checker.sv
// Receive-side lock-and-compare checker for an xorshift32 (13/17/5) word stream.
// Define XORSHIFT_CHECK_ERRCNT_EN to add the saturating err_count port and counter.
module xorshift32_checker #(
    parameter int LOCK_MATCHES  = 2,
    parameter int RELOCK_THRESH = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              locked,
    output logic              mismatch,
    output logic              lost,
`ifdef XORSHIFT_CHECK_ERRCNT_EN
    output logic              zero_seen,
    output logic [CNT_W-1:0]  err_count
`else
    output logic              zero_seen
`endif
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int XW = $clog2(RELOCK_THRESH + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    function automatic logic [31:0] xs_next(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    state_t         state, state_n;
    logic [31:0]    pred, pred_n;
    logic [MW-1:0]  match_run, match_n;
    logic [XW-1:0]  miss_run, miss_n;
    logic           mm_n, lost_n, zero_n;
    logic           is_zero, hit;
    logic [31:0]    nxt_in, nxt_pred;

    assign is_zero  = (in_data == 32'd0);
    assign hit      = (in_data == pred);
    assign nxt_in   = xs_next(in_data);
    assign nxt_pred = xs_next(pred);

    always_comb begin
        state_n = state;
        pred_n  = pred;
        match_n = match_run;
        miss_n  = miss_run;
        mm_n    = 1'b0;
        lost_n  = 1'b0;
        zero_n  = 1'b0;
        if (in_valid) begin
            zero_n = is_zero;
            case (state)
                IDLE: begin
                    if (!is_zero) begin
                        pred_n  = nxt_in;
                        match_n = '0;
                        state_n = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (hit) begin
                        pred_n  = nxt_in;
                        match_n = match_run + 1'b1;
                        if (int'(match_run) + 1 == LOCK_MATCHES) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else if (!is_zero) begin
                        pred_n  = nxt_in;
                        match_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                LOCKED: begin
                    // Prediction free-runs through errors so a lone bad word keeps lock
                    pred_n = nxt_pred;
                    if (hit) begin
                        miss_n = '0;
                    end else begin
                        mm_n   = 1'b1;
                        miss_n = miss_run + 1'b1;
                        if (int'(miss_run) + 1 == RELOCK_THRESH) begin
                            lost_n = 1'b1;
                            if (!is_zero) begin
                                state_n = ACQUIRE;
                                pred_n  = nxt_in;
                                match_n = '0;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pred      <= '0;
            match_run <= '0;
            miss_run  <= '0;
            mismatch  <= 1'b0;
            lost      <= 1'b0;
            zero_seen <= 1'b0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            match_run <= match_n;
            miss_run  <= miss_n;
            mismatch  <= mm_n;
            lost      <= lost_n;
            zero_seen <= zero_n;
        end
    end

    assign locked = (state == LOCKED);

`ifdef XORSHIFT_CHECK_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (mm_n && err_count != '1)
            err_count <= err_count + 1'b1;
    end
`endif

endmodule

// File: doc/xorshift32_checker.md
# xorshift32_checker

Receive-side checker for the `xorshift32` pseudo-random stream. It consumes 32-bit samples on a valid strobe and locks onto the sequence. While locked, it predicts each next word and flags every sample that deviates from the prediction. It sits at the far end of any link carrying generator output (FIFO, serializer, bus), so benches and on-chip self-test can confirm end-to-end integrity without a golden copy of the generator.

## Interface
- `LOCK_MATCHES`, default 2: consecutive correct predictions needed to enter LOCKED (≥1).
- `RELOCK_THRESH`, default 4: consecutive mismatches in LOCKED that force re-acquisition (≥1).
- `CNT_W`, default 16: width of `err_count`.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_data` is a sample this cycle.
- `in_data`, in, 32: received generator word.
- `locked`, out, 1: high while in LOCKED.
- `mismatch`, out, 1: one-cycle pulse when a LOCKED sample differs from the prediction.
- `lost`, out, 1: one-cycle pulse on the LOCKED→ACQUIRE/IDLE exit.
- `zero_seen`, out, 1: one-cycle pulse on any valid sample equal to 0. Zero is the illegal fixed point of the generator.
- `err_count`, out, CNT_W: saturating mismatch counter. Present only with `XORSHIFT_CHECK_ERRCNT_EN`.

## Operation
- `next(v)` is one generator step: `t=v^(v<<13); t=t^(t>>17); t=t^(t<<5)`. All shifts are 32-bit logical and truncate.
- Internal registers: `pred[31:0]`, `state`, `match_run`, `miss_run`.
- Cycles with `in_valid`=0 change nothing, and all pulses are low.
- IDLE:
  - Valid nonzero sample: `pred<=next(in_data)`, `match_run<=0`, go to ACQUIRE.
  - Valid zero sample: stay in IDLE, pulse `zero_seen`.
- ACQUIRE, valid sample:
  - If `in_data==pred`: `match_run++` and `pred<=next(in_data)`. When `match_run+1==LOCK_MATCHES`, go to LOCKED with `miss_run<=0`.
  - Otherwise, if the sample is nonzero: reseed with `pred<=next(in_data)` and `match_run<=0`, staying in ACQUIRE.
  - Otherwise (zero): go to IDLE and pulse `zero_seen`.
  - No `mismatch` pulse is generated in ACQUIRE.
- LOCKED, valid sample:
  - Match: `pred<=next(pred)`, `miss_run<=0`.
  - Mismatch: pulse `mismatch`, increment `err_count`, `miss_run++`, `pred<=next(pred)`. The prediction free-runs so isolated corrupted words do not break lock.
  - When `miss_run+1==RELOCK_THRESH`: pulse `lost`. Reseed from `in_data` into ACQUIRE if nonzero, else go to IDLE.
  - A zero sample in LOCKED is handled as a mismatch and additionally pulses `zero_seen`.
- `err_count` saturates at all-ones. It is never cleared except by `reset`.

## Timing
- All outputs are registered. Effects of the sample at edge N are visible after edge N; the decision latency is 1 cycle.
- Back-to-back `in_valid` every cycle is supported at full rate, with no backpressure.
- Reset values: state IDLE, `pred`=0, `locked`=0, `mismatch`=0, `lost`=0, `zero_seen`=0, `err_count`=0, both run counters 0.
- `reset` overrides `in_valid` in the same cycle. A sample presented during reset is discarded. Reset in mid-lock returns to IDLE in one cycle.
- `locked` rises on the same edge as the LOCK_MATCHES-th match and falls on the same edge as the `lost` pulse.
- `LOCK_MATCHES`=1: the first correct prediction locks. `RELOCK_THRESH`=1: the first mismatch exits lock. Both the `mismatch` and `lost` pulses fire on that edge.

## Configuration
- `XORSHIFT_CHECK_ERRCNT_EN` defined: `err_count` port and saturating counter are present.
- Not defined: the port and counter are removed. `mismatch` and `lost` behaviour is unchanged.

## Test plan
- Seed stream 1, 0x00042021, 0x04080601, next(0x04080601) → `locked`=1 one cycle after the third sample. No `mismatch`, `err_count`=0.
- While locked, replace one word with its bit-0-flipped value → a single `mismatch` pulse and `err_count`=1. The following correct word matches, with no `lost`.
- While locked, inject 4 consecutive wrong nonzero words (RELOCK_THRESH=4) → 4 `mismatch` pulses; `lost` and `locked`↓ on the 4th; then 2 correct successors of the 4th word relock.
- Samples 0 in IDLE, then 0 while locked → `zero_seen` pulses each time; IDLE stays IDLE; in LOCKED it also counts as a mismatch.
- Hold `in_valid`=0 for 10 cycles mid-lock, then resume the correct sequence → still locked, no pulses. Assert `reset` mid-lock with `in_valid`=1 → next cycle all outputs are 0 and the sample is ignored.
- Force 2^CNT_W+3 mismatches (CNT_W=4, RELOCK_THRESH large) → `err_count` holds at 0xF.
